// File: rtl/im_fetch_if.sv
// im_fetch_if: loader, instruction-memory and decode-side signals of im_fetch_ctrl.
// master is the controller side; slave is the loader/memory/decode side.
interface im_fetch_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              load_ready;
    logic [ADDR_W-1:0] im_addr;
    logic              im_we;
    logic [DATA_W-1:0] im_wdata;
    logic [DATA_W-1:0] im_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;

    modport master (
        input  load_valid, load_data, load_done, im_rdata, stall, redirect_valid, redirect_pc,
        output load_ready, im_addr, im_we, im_wdata, instr, instr_pc, instr_valid, halted
    );
    modport slave (
        output load_valid, load_data, load_done, im_rdata, stall, redirect_valid, redirect_pc,
        input  load_ready, im_addr, im_we, im_wdata, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: boot-loads the instruction memory, then fetches with stall/redirect/halt.
// Define IM_FETCH_PERF_EN to add the saturating fetch_cnt advance counter port.
module im_fetch_ctrl #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input logic         clk,
    input logic         reset_n,
    im_fetch_if.master  bus
`ifdef IM_FETCH_PERF_EN
    ,
    output logic [15:0] fetch_cnt
`endif
);
    typedef enum logic [1:0] {LOAD, FETCH, HALT} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, pc;
    logic              advance;

    always_comb begin
        state_n        = state;
        advance        = state == FETCH && !bus.redirect_valid && !bus.stall;
        bus.load_ready = state == LOAD;
        bus.halted     = state == HALT;
        bus.im_addr    = state == LOAD ? cnt : pc;
        bus.im_we      = state == LOAD && bus.load_valid;
        bus.im_wdata   = bus.load_data;
        // the last word written into a full memory ends loading just like load_done
        if (state == LOAD && (bus.load_done || (bus.load_valid && cnt == '1)))
            state_n = FETCH;
        if (advance && bus.im_rdata == HALT_WORD)
            state_n = HALT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= LOAD;
            cnt             <= '0;
            pc              <= '0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.im_we)
                cnt <= cnt + ADDR_W'(1);
            if (state == LOAD)
                pc <= '0;
            if (state == FETCH && bus.redirect_valid) begin
                pc              <= bus.redirect_pc;
                bus.instr_valid <= 1'b0;
            end else if (advance) begin
                bus.instr       <= bus.im_rdata;
                bus.instr_pc    <= pc;
                bus.instr_valid <= 1'b1;
                pc              <= pc + ADDR_W'(1);
            end
            if (state == HALT)
                bus.instr_valid <= 1'b0;
        end
    end

`ifdef IM_FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fetch_cnt <= '0;
        else if (advance && fetch_cnt != 16'hFFFF)
            fetch_cnt <= fetch_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: directed and randomized checks of im_fetch_ctrl against a behavioural model.
module tb_im_fetch_ctrl;
    localparam int          AW = 5;
    localparam int          DW = 32;
    localparam logic [31:0] HW = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    im_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
`ifdef IM_FETCH_PERF_EN
    logic [15:0] fetch_cnt;
`endif

    im_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .HALT_WORD(HW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
`ifdef IM_FETCH_PERF_EN
        ,
        .fetch_cnt(fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32] = '{default: 32'h0};
    assign bus.im_rdata = mem[bus.im_addr];
    always @(posedge clk) if (bus.im_we) mem[bus.im_addr] <= bus.im_wdata;

    // model: phase 0 = loading, 1 = fetching, 2 = halted
    logic [31:0] mmem [32] = '{default: 32'h0};
    int          ph = 0, mcnt = 0, mpc = 0, mipc = 0, mfc = 0;
    logic [31:0] minstr = 0;
    bit          miv = 0;
    int          total = 0, passed = 0;
    logic [31:0] prog [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic mreset();
        ph = 0; mcnt = 0; mpc = 0; mipc = 0; mfc = 0; minstr = 0; miv = 0;
    endtask

    task automatic mstep();
        bit full;
        if (!reset_n) return;
        case (ph)
            0: begin
                full = bus.load_valid && mcnt == 31;
                if (bus.load_valid) begin
                    mmem[mcnt] = bus.load_data;
                    mcnt = (mcnt + 1) % 32;
                end
                if (bus.load_done || full) begin ph = 1; mpc = 0; end
            end
            1: begin
                if (bus.redirect_valid) begin
                    mpc = int'(bus.redirect_pc);
                    miv = 0;
                end else if (!bus.stall) begin
                    minstr = mmem[mpc];
                    mipc = mpc;
                    miv = 1;
                    mpc = (mpc + 1) % 32;
                    if (mfc < 65535) mfc++;
                    if (minstr == HW) ph = 2;
                end
            end
            default: miv = 0;
        endcase
    endtask

    always @(negedge clk) begin
        chk("load_ready", 32'(bus.load_ready), 32'(ph == 0));
        chk("halted", 32'(bus.halted), 32'(ph == 2));
        chk("im_addr", 32'(bus.im_addr), 32'(ph == 0 ? mcnt : mpc));
        chk("im_we", 32'(bus.im_we), 32'(ph == 0 && bus.load_valid));
        if (ph == 0 && bus.load_valid) chk("im_wdata", bus.im_wdata, bus.load_data);
        chk("instr", bus.instr, minstr);
        chk("instr_pc", 32'(bus.instr_pc), 32'(mipc));
        chk("instr_valid", 32'(bus.instr_valid), 32'(miv));
`ifdef IM_FETCH_PERF_EN
        chk("fetch_cnt", 32'(fetch_cnt), 32'(mfc));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        mstep();
        #1;
    endtask

    task automatic idle();
        bus.load_valid = 0; bus.load_data = 0; bus.load_done = 0;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        mreset();
        cyc();
        cyc();
        reset_n = 1;
    endtask

    task automatic load(input int n, input bit done);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1;
            bus.load_data = prog[i];
            cyc();
        end
        bus.load_valid = 0;
        if (done) begin
            bus.load_done = 1;
            cyc();
            bus.load_done = 0;
        end
    endtask

    task automatic rand_prog();
        for (int i = 0; i < 32; i++) begin
            prog[i] = $urandom;
            if (prog[i] == HW) prog[i] = 32'h1234;
        end
    endtask

    initial begin
        idle();
        #1 reset_n = 0;
        mreset();
        #2;
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_im_addr", 32'(bus.im_addr), 32'd0);
        do_reset();

        // four-word program, then load_done
        prog[0] = 32'h200; prog[1] = 32'h201; prog[2] = 32'h204; prog[3] = 32'h108;
        load(4, 1);
        chk("s1_bubble", 32'(bus.instr_valid), 32'd0);
        cyc(); chk("s1_i0", bus.instr, 32'h200); chk("s1_pc0", 32'(bus.instr_pc), 32'd0);
        chk("s1_v0", 32'(bus.instr_valid), 32'd1);
        cyc(); chk("s1_i1", bus.instr, 32'h201); chk("s1_pc1", 32'(bus.instr_pc), 32'd1);
        cyc(); chk("s1_i2", bus.instr, 32'h204); chk("s1_pc2", 32'(bus.instr_pc), 32'd2);
        cyc(); chk("s1_i3", bus.instr, 32'h108); chk("s1_pc3", 32'(bus.instr_pc), 32'd3);

        // full memory auto-enters fetch; pc wraps 31 -> 0
        do_reset();
        rand_prog();
        load(32, 0);
        chk("s2_fetch", 32'(bus.load_ready), 32'd0);
        repeat (32) cyc();
        chk("s2_pc31", 32'(bus.instr_pc), 32'd31);
        chk("s2_i31", bus.instr, prog[31]);
        cyc();
        chk("s2_pc0", 32'(bus.instr_pc), 32'd0);
        chk("s2_i0", bus.instr, prog[0]);

        // three-cycle stall at pc=2
        do_reset();
        rand_prog();
        load(8, 1);
        cyc(); cyc();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s3_hold_i", bus.instr, prog[1]);
            chk("s3_hold_pc", 32'(bus.instr_pc), 32'd1);
            chk("s3_hold_v", 32'(bus.instr_valid), 32'd1);
            chk("s3_addr", 32'(bus.im_addr), 32'd2);
        end
        bus.stall = 0;
        cyc();
        chk("s3_resume_pc", 32'(bus.instr_pc), 32'd2);
        chk("s3_resume_i", bus.instr, prog[2]);

        // redirect wins over stall
        bus.stall = 1; bus.redirect_valid = 1; bus.redirect_pc = 5;
        cyc();
        bus.stall = 0; bus.redirect_valid = 0;
        chk("s4_bubble", 32'(bus.instr_valid), 32'd0);
        chk("s4_keep_i", bus.instr, prog[2]);
        cyc();
        chk("s4_i5", bus.instr, prog[5]);
        chk("s4_pc5", 32'(bus.instr_pc), 32'd5);
        chk("s4_v", 32'(bus.instr_valid), 32'd1);

        // halt on sentinel at address 3, then asynchronous reset
        do_reset();
        rand_prog();
        prog[3] = HW;
        load(6, 1);
        repeat (4) cyc();
        chk("s5_hw", bus.instr, HW);
        chk("s5_hw_v", 32'(bus.instr_valid), 32'd1);
        bus.redirect_valid = 1; bus.redirect_pc = 7;
        cyc();
        chk("s5_v0", 32'(bus.instr_valid), 32'd0);
        chk("s5_halted", 32'(bus.halted), 32'd1);
        chk("s5_addr", 32'(bus.im_addr), 32'd4);
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1; bus.stall = 1'($urandom);
            cyc();
            chk("s5_we", 32'(bus.im_we), 32'd0);
            chk("s5_still_v0", 32'(bus.instr_valid), 32'd0);
        end
        idle();
        #2 reset_n = 0;
        mreset();
        #1;
        chk("s5_async_ready", 32'(bus.load_ready), 32'd1);
        chk("s5_async_halted", 32'(bus.halted), 32'd0);
        do_reset();

`ifdef IM_FETCH_PERF_EN
        rand_prog();
        load(16, 1);
        repeat (10) cyc();
        bus.stall = 1;
        repeat (2) cyc();
        bus.stall = 0; bus.redirect_valid = 1; bus.redirect_pc = 9;
        cyc();
        bus.redirect_valid = 0;
        chk("perf_cnt", 32'(fetch_cnt), 32'd10);
        do_reset();
`endif

        // randomized loads (with occasional sentinels) and fetch traffic
        for (int it = 0; it < 20; it++) begin
            int n, loaded;
            bit lv;
            do_reset();
            n = $urandom_range(1, 32);
            loaded = 0;
            for (int g = 0; g < 200 && ph == 0; g++) begin
                lv = ($urandom % 3) != 0;
                bus.load_valid = lv;
                bus.load_data = ($urandom % 16 == 0) ? HW : $urandom;
                bus.load_done = (loaded + int'(lv) >= n) && ($urandom % 2 == 1);
                cyc();
                loaded += int'(lv);
            end
            if (ph == 0) begin
                idle();
                bus.load_done = 1;
                cyc();
            end
            for (int c = 0; c < 150; c++) begin
                bus.stall = ($urandom % 4) == 0;
                bus.redirect_valid = ($urandom % 8) == 0;
                bus.redirect_pc = 5'($urandom);
                bus.load_valid = 1'($urandom);
                bus.load_done = 1'($urandom);
                bus.load_data = $urandom;
                cyc();
            end
        end
        idle();
        cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
- Sequencer for the 32-entry x 32-bit instruction memory.
- Boot phase: loader interface writes program words into memory sequentially from address 0.
- Fetch phase: drives the PC into the memory, registers the returned instruction with a valid flag, and supports stall, redirect (branch/jump) and halt-on-sentinel.
- Sits between the boot loader / top level and the decode stage; it is the only writer of the memory address and write enable.

Parameters:
- ADDR_W, 5, PC / memory address width (depth = 2^ADDR_W = 32)
- DATA_W, 32, instruction width
- HALT_WORD, 32'hFFFFFFFF, fetched instruction value that stops fetching

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- load_valid  in  1  loader presents a word
- load_data  in  DATA_W  word to write
- load_done  in  1  loader finished (pulse, may coincide with load_valid)
- load_ready  out  1  controller accepts load words (LOAD state)
- im_addr  out  ADDR_W  memory address
- im_we  out  1  memory write enable
- im_wdata  out  DATA_W  memory write data
- im_rdata  in  DATA_W  memory read data, combinational from im_addr
- stall  in  1  decode cannot accept; hold fetch
- redirect_valid  in  1  load new PC
- redirect_pc  in  ADDR_W  redirect target
- instr  out  DATA_W  registered instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr is valid
- halted  out  1  HALT state

Behaviour:
- States: LOAD, FETCH, HALT. Reset (reset_n low, async) forces:
  - state=LOAD
  - load counter=0, pc=0
  - instr=0, instr_pc=0, instr_valid=0, halted=0
  - load_ready=1 (combinational from state)
- LOAD:
  - im_addr=load counter; im_we=load_valid; im_wdata=load_data.
  - On load_valid: write occurs at clk edge and counter increments.
  - Transition to FETCH with pc=0 on either:
    - load_done, or
    - an accepted write at counter=2^ADDR_W-1 (memory full).
  - If load_done and load_valid fall in the same cycle, the word is written, then the transition occurs.
  - stall and redirect_valid are ignored in LOAD.
  - instr_valid=0 throughout LOAD.
- FETCH:
  - im_addr=pc, im_we=0, load_ready=0.
  - Each cycle, priority is redirect > stall > advance:
    - Redirect: pc<=redirect_pc; instr_valid<=0 next cycle (one bubble); instr unchanged.
    - Stall (no redirect): pc, instr, instr_pc, instr_valid all hold.
    - Advance: instr<=im_rdata; instr_pc<=pc; instr_valid<=1; pc<=pc+1.
  - Latency: word at address A appears on instr one cycle after im_addr=A.
  - Wrap-around: pc=31 advances to 0 (modulo 2^ADDR_W); no error.
  - Halt: when an advance captures im_rdata==HALT_WORD:
    - next state is HALT;
    - the HALT_WORD is presented once with instr_valid=1, then instr_valid drops to 0.
- HALT:
  - halted=1, instr_valid=0, pc frozen, im_we=0.
  - stall, redirect and load inputs are ignored.
  - Leaves HALT only through reset.
- Reset mid-operation (any state): immediate return to LOAD. Memory contents are not cleared; the loader may reload any prefix.
- im_we is never asserted outside LOAD.

Optional Feature:
- Macro: IM_FETCH_PERF_EN.
- Defined:
  - adds output port fetch_cnt[15:0], reset to 0;
  - increments on every cycle that sets instr_valid<=1 via advance;
  - saturates at 16'hFFFF;
  - holds in HALT; clears only on reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Load 4 words (00000200, 00000201, 00000204, 00000108), then load_done, no stall → instr sequence 00000200@0, 00000201@1, 00000204@2, 00000108@3 on consecutive cycles, with instr_valid=1 starting one cycle after entering FETCH.
- Load 32 words without load_done → auto-enter FETCH after the 32nd write; fetch runs 31→0 wrap, and instr_pc shows 31 then 0.
- Stall 3 cycles at pc=2 → instr/instr_pc/instr_valid held 3 cycles, im_addr held at 2, fetch resumes with address 2's word next.
- redirect_valid=1, redirect_pc=5 asserted together with stall=1 → one bubble (instr_valid=0), then instr=mem[5] with instr_pc=5.
- Word 3 = FFFFFFFF → instr FFFFFFFF shown once valid, then halted=1, instr_valid=0 permanently; redirect ignored; reset_n low returns to LOAD asynchronously (load_ready=1 before the next clk edge).
- With IM_FETCH_PERF_EN, 10 advances + 2 stall cycles + 1 redirect → fetch_cnt=10.
